// File: rtl/keypad_ssd_pkg.sv
// Shared types and constants for the keypad entry buffer and its
// multiplexed seven-segment display driver.
package keypad_ssd_pkg;

    typedef enum logic {
        ENTRY_SHIFT = 1'b0,
        ENTRY_SLOT  = 1'b1
    } entry_mode_t;

    localparam logic [3:0] KEY_CLR_DEFAULT = 4'hC;
    localparam logic [6:0] SEG_BLANK       = 7'b0;

endpackage

// File: rtl/disp_ctrl.sv
// Hex-to-seven-segment encoder, active-high segments packed as {g,f,e,d,c,b,a}.
module disp_ctrl (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/ssd_scan_timer.sv
// Digit scan timer: dwell prescaler, current digit index and one-hot select.
module ssd_scan_timer #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 2,
    localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [IW-1:0]         idx,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam int DIV   = CLK_FREQ / SCAN_HZ;
    localparam int DWELL = (DIV < 1) ? 1 : DIV;
    localparam int PW    = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  terminal;

    always_comb begin
        terminal = (pre_q == PW'(DWELL - 1));
        pre_d    = terminal ? '0 : pre_q + 1'b1;
        idx_d    = idx_q;
        sel_d    = sel_q;
        if (terminal) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            sel_d = NUM_DIGITS'(1) << idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            sel_q <= NUM_DIGITS'(1);
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
        end
    end

    assign idx       = idx_q;
    assign digit_sel = sel_q;

endmodule

// File: rtl/keypad_ssd_multi.sv
// N-digit keypad entry buffer (shift or left-to-right slot fill) with a
// time-multiplexed seven-segment display on a shared segment bus.
module keypad_ssd_multi
    import keypad_ssd_pkg::*;
#(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         SCAN_HZ      = 1000,
    parameter int         NUM_DIGITS   = 2,
    parameter bit         BLANK_UNUSED = 1'b1,
    parameter bit         CLR_EN       = 1'b1,
    parameter logic [3:0] CLR_CODE     = KEY_CLR_DEFAULT,
    parameter logic [6:0] BLANK_SEG    = SEG_BLANK,
    localparam int        CW           = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    mode,
    input  logic                    hold,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   valid_out,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    entry_done
);

    localparam int            IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int            WP_RESTART = (NUM_DIGITS > 1) ? NUM_DIGITS - 2 : NUM_DIGITS - 1;
    localparam logic [IW-1:0] WP_LAST    = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(NUM_DIGITS);

    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]      valid_q, valid_d;
    logic [CW-1:0]              count_q, count_d;
    logic [IW-1:0]              wp_q, wp_d;
    entry_mode_t                mode_q, mode_d;
    logic                       entry_done_q, entry_done_d;
    logic [6:0]                 seg_q, seg_d;

    logic [IW-1:0] scan_idx;
    logic [6:0]    hex_seg;
    logic          mode_change, accept, is_clr, is_full;

    ssd_scan_timer #(
        .CLK_FREQ  (CLK_FREQ),
        .SCAN_HZ   (SCAN_HZ),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (scan_idx),
        .digit_sel(digit_sel)
    );

    disp_ctrl u_disp (
        .hex(digits_q[scan_idx]),
        .seg(hex_seg)
    );

    // A mode change wins over any key in the same cycle and wipes the buffer.
    always_comb begin
        mode_change = (entry_mode_t'(mode) != mode_q);
        accept      = key_valid && !hold && !mode_change;
        is_clr      = CLR_EN && (key_code == CLR_CODE);
        is_full     = (count_q == CNT_FULL);

        digits_d     = digits_q;
        valid_d      = valid_q;
        count_d      = count_q;
        wp_d         = wp_q;
        mode_d       = entry_mode_t'(mode);
        entry_done_d = 1'b0;

        if (mode_change || (accept && is_clr)) begin
            digits_d = '0;
            valid_d  = '0;
            count_d  = '0;
            wp_d     = WP_LAST;
        end else if (accept) begin
            if (mode_q == ENTRY_SHIFT) begin
                for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                    digits_d[i] = digits_q[i-1];
                    valid_d[i]  = valid_q[i-1];
                end
                digits_d[0] = key_code;
                valid_d[0]  = 1'b1;
                count_d     = is_full ? count_q : count_q + 1'b1;
            end else if (is_full) begin
                digits_d                 = '0;
                valid_d                  = '0;
                digits_d[NUM_DIGITS-1]   = key_code;
                valid_d[NUM_DIGITS-1]    = 1'b1;
                count_d                  = CW'(1);
                wp_d                     = IW'(WP_RESTART);
            end else begin
                digits_d[wp_q] = key_code;
                valid_d[wp_q]  = 1'b1;
                count_d        = count_q + 1'b1;
                wp_d           = (wp_q == '0) ? WP_LAST : wp_q - 1'b1;
            end
            entry_done_d = (count_q == CW'(NUM_DIGITS - 1)) && (count_d == CNT_FULL);
        end
    end

    always_comb begin
        seg_d = (BLANK_UNUSED && !valid_q[scan_idx]) ? BLANK_SEG : hex_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q     <= '0;
            valid_q      <= '0;
            count_q      <= '0;
            wp_q         <= WP_LAST;
            mode_q       <= entry_mode_t'(mode);
            entry_done_q <= 1'b0;
            seg_q        <= BLANK_SEG;
        end else begin
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            wp_q         <= wp_d;
            mode_q       <= mode_d;
            entry_done_q <= entry_done_d;
            seg_q        <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign digits_out = digits_q;
    assign valid_out  = valid_q;
    assign count      = count_q;
    assign full       = (count_q == CNT_FULL);
    assign entry_done = entry_done_q;

endmodule

// File: doc/keypad_ssd_multi.md
Name: keypad_ssd_multi

Overview:
Parametrised N-digit keypad entry buffer with a time-multiplexed seven-segment display driver. It consumes single-cycle key events (4-bit hex code plus valid pulse) from the existing decoder, debounce and pulse chain. It stores digits in one of two entry modes, supports a clear key and hold, and scans the stored digits onto a shared segment bus with a one-hot digit select. It generalises the fixed two-digit alternate-capture and chip-select toggle to NUM_DIGITS digits.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
SCAN_HZ, 1000, digit-switch rate in Hz; DWELL = max(1, CLK_FREQ/SCAN_HZ) cycles per digit
NUM_DIGITS, 2, number of display digits/buffer slots, >=1
BLANK_UNUSED, 1, 1 = positions without a valid entry drive BLANK_SEG
CLR_EN, 1, 1 = key code CLR_CODE clears the buffer instead of being stored
CLR_CODE, 4'hC, clear key code
BLANK_SEG, 7'b0000000, segment pattern for a blanked digit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle key event strobe
key_code  in  4  hex key value, sampled when key_valid=1
mode  in  1  0 = shift entry, 1 = slot fill
hold  in  1  1 = ignore key events; scanning continues
seg  out  7  segment pattern of the currently selected digit, same encoding as disp_ctrl
digit_sel  out  NUM_DIGITS  one-hot select; bit i = digit i (digit 0 rightmost)
digits_out  out  4*NUM_DIGITS  stored codes; [3:0] = digit 0
valid_out  out  NUM_DIGITS  per-digit entry-valid mask
count  out  $clog2(NUM_DIGITS+1)  number of valid digits
full  out  1  count == NUM_DIGITS
entry_done  out  1  one-cycle pulse when count becomes NUM_DIGITS

Behaviour:
- Reset (async assert, sync release): digits=0, valid=0, count=0, full=0, entry_done=0, scan idx=0, digit_sel=1, seg=BLANK_SEG, slot pointer wp=NUM_DIGITS-1, mode_q=mode.
- Key accept: key_valid & ~hold & ~mode_change. Registered outputs update the cycle after the accept (latency 1).
- Clear (CLR_EN & key_code==CLR_CODE): digits=0, valid=0, count=0, wp=NUM_DIGITS-1. The code is not stored and entry_done stays 0.
- Shift mode (mode=0): digit[i] <= digit[i-1], valid[i] <= valid[i-1], digit[0] <= key_code, valid[0] <= 1. count saturates at NUM_DIGITS. When full, the oldest digit is dropped and full stays 1.
- Slot mode (mode=1): writes go left to right. digit[wp] <= key_code, valid[wp] <= 1, then wp decrements. After slot 0 is written, wp <= NUM_DIGITS-1.
  - If a key arrives while full: restart. All digits and valid bits are cleared, the key goes to digit[NUM_DIGITS-1], count=1, wp=NUM_DIGITS-2 (or NUM_DIGITS-1 if NUM_DIGITS=1).
- entry_done fires only on the transition count NUM_DIGITS-1 -> NUM_DIGITS. In shift mode it does not re-fire while saturated.
- Mode change: mode_q registers mode. When mode != mode_q, the buffer clears exactly as for the clear key. Any key_valid in that same cycle is dropped.
- hold=1 drops keys with no state change. Clear is also suppressed.
- Scan: prescaler counts 0..DWELL-1. At terminal count, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, and digit_sel <= 1<<next idx.
  - seg is registered: seg <= (BLANK_UNUSED & ~valid[idx]) ? BLANK_SEG : hex7(digit[idx]), evaluated every cycle.
  - A stored key therefore appears on seg 2 cycles after the accept if its digit is currently selected.
- NUM_DIGITS=1: the scan idx stays at 0 and digit_sel stays 1. Both modes behave as overwrite, and entry_done fires only on the first key after a clear.
- Reset mid-scan or mid-entry returns everything to reset values; no partial state is retained.

Decomposition:
- Package keypad_ssd_pkg:
  - typedef enum logic {ENTRY_SHIFT, ENTRY_SLOT} entry_mode_t
  - localparam KEY_CLR_DEFAULT = 4'hC
  - localparam SEG_BLANK = 7'b0
- Sub-module ssd_scan_timer (CLK_FREQ, SCAN_HZ, NUM_DIGITS) provides the prescaler, idx and one-hot digit_sel.
- Reuse disp_ctrl for hex-to-segment encoding.

Test Plan:
1. Reset: rst_n=0 mid-scan -> seg=BLANK_SEG, digit_sel=1, count=0, digits_out=0 immediately (async).
2. Shift mode, NUM_DIGITS=4, keys 1,2,3,4,5 -> digits_out=16'h2345, count=4, full=1; entry_done pulses once, on the 4th key only.
3. Slot mode, NUM_DIGITS=2, keys 7,9 -> digits_out=8'h79, entry_done on the 2nd key. Then key 3 -> digits_out=8'h30, valid_out=2'b10, count=1.
4. Shift mode, keys A,B,C with CLR_EN=1 -> after C: digits_out=0, count=0, valid_out=0; seg shows BLANK_SEG on every scan position.
5. Scan, CLK_FREQ=100, SCAN_HZ=10, NUM_DIGITS=4 -> digit_sel cycles 1,2,4,8,1 every 10 cycles; seg tracks hex7 of the selected digit 1 cycle later.
6. Hold and mode: hold=1 with key 5 -> no output change. Toggle mode with key_valid in the same cycle -> buffer cleared, key dropped, count=0.
